// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types for the APB requester: FSM state encoding and
//               the packed command record latched at acceptance.
//               The command struct is sized for the widest supported bus
//               (64-bit address and data); narrower instances use the low
//               slices only.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_MAX_ADDR_W = 64;
    localparam int APB_MAX_DATA_W = 64;
    localparam int APB_MAX_STRB_W = APB_MAX_DATA_W / 8;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int APB_WDOG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_MAX_ADDR_W-1:0] addr;
        logic [APB_MAX_DATA_W-1:0] wdata;
        logic [APB_MAX_STRB_W-1:0] strb;
    } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_if
// Description : Bundles the local command/response handshake and the APB
//               requester pins of apb_master.
//               master : view taken by apb_master
//               slave  : view taken by the local requester plus APB completer
// Ports       : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_strb,
//               rsp_valid/rsp_ready/rsp_rdata/rsp_err,
//               psel/penable/pwrite/paddr/pwdata/pstrb/prdata/pready
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready
    );

endinterface
`default_nettype wire

// File: rtl/apb_wdog.sv
`default_nettype none
// ============================================================================
// Module      : apb_wdog
// Description : ACCESS-phase wait counter. Counts cycles in which the
//               completer holds pready low; expired fires on the cycle whose
//               increment would bring the count to TIMEOUT, so a completer
//               that never answers sees exactly TIMEOUT ACCESS cycles.
// Ports       : pclk, presetn (async, active-low)
//               clr     - clear count (entry into SETUP)
//               inc     - ACCESS cycle with pready low
//               expired - this wait cycle exhausts the budget
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16      // legal range 1..255
) (
    input  wire logic pclk,
    input  wire logic presetn,
    input  wire logic clr,
    input  wire logic inc,
    output logic      expired
);

    localparam logic [APB_WDOG_W-1:0] c_LAST = APB_WDOG_W'(TIMEOUT - 1);
    localparam logic [APB_WDOG_W-1:0] c_ONE  = APB_WDOG_W'(1);

    logic [APB_WDOG_W-1:0] r_count;

    // The FSM leaves ACCESS on expiry, so the count never passes TIMEOUT.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign expired = inc && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB requester. A local command is latched
//               in IDLE, issued as one SETUP cycle followed by ACCESS cycles
//               until pready or the wait budget runs out, and the result is
//               held in RESP until the requester consumes it.
// Ports       : pclk, presetn (async assert, active-low)
//               bus (apb_master_if.master): command, response and APB pins
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic      pclk,
    input  wire logic      presetn,
    apb_master_if.master   bus
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] c_IDLE   = ST_IDLE;
    localparam logic [1:0] c_SETUP  = ST_SETUP;
    localparam logic [1:0] c_ACCESS = ST_ACCESS;
    localparam logic [1:0] c_RESP   = ST_RESP;

    logic [1:0]        r_state;
    logic              r_live;      // low until the first edge after reset
    apb_cmd_t          r_cmd;
    apb_cmd_t          w_cmd;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic w_in_setup;
    logic w_in_access;
    logic w_in_resp;
    logic w_accept;
    logic w_wait;
    logic w_expired;
    logic w_unused_cmd;

    assign w_in_setup  = (r_state == c_SETUP);
    assign w_in_access = (r_state == c_ACCESS);
    assign w_in_resp   = (r_state == c_RESP);

    assign bus.cmd_ready = r_live && (r_state == c_IDLE);
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_wait        = w_in_access && !bus.pready;

    // Reads never carry byte strobes, so the strobe is masked once here
    // and pstrb can be driven straight from the latched command.
    always_comb begin
        w_cmd                   = '0;
        w_cmd.write             = bus.cmd_write;
        w_cmd.addr[ADDR_W-1:0]  = bus.cmd_addr;
        w_cmd.wdata[DATA_W-1:0] = bus.cmd_wdata;
        w_cmd.strb[STRB_W-1:0]  = bus.cmd_write ? bus.cmd_strb : '0;
    end

    apb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .pclk    (pclk),
        .presetn (presetn),
        .clr     (w_accept),
        .inc     (w_wait),
        .expired (w_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= c_IDLE;
            r_live  <= 1'b0;
            r_cmd   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= w_cmd;
                        r_state <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_state <= c_ACCESS;
                end
                c_ACCESS: begin
                    if (bus.pready) begin
                        r_rdata <= r_cmd.write ? '0 : bus.prdata;
                        r_err   <= 1'b0;
                        r_state <= c_RESP;
                    end else if (w_expired) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // psel/penable decode straight from the state register so an
    // asynchronous reset drops them without waiting for an edge.
    assign bus.psel      = w_in_setup || w_in_access;
    assign bus.penable   = w_in_access;
    assign bus.pwrite    = r_cmd.write;
    assign bus.paddr     = r_cmd.addr[ADDR_W-1:0];
    assign bus.pwdata    = r_cmd.wdata[DATA_W-1:0];
    assign bus.pstrb     = r_cmd.strb[STRB_W-1:0];

    assign bus.rsp_valid = w_in_resp;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    // Upper bits of the max-width command record are constant zero for
    // narrow instances.
    assign w_unused_cmd = ^r_cmd;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master
// Description : Self-checking bench for apb_master (32-bit, TIMEOUT=16).
//               A transaction-timeline model predicts every output each
//               cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int TIMEOUT = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk    (clk),
        .presetn (rstn),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: one outstanding transaction, phases derived from cycle offset
    // since acceptance and the completer's chosen wait count.
    // ------------------------------------------------------------------
    logic        m_live = 1'b0;
    logic        m_has  = 1'b0;
    logic        m_wr;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_strb;
    int          m_w    = 0;
    int          m_tacc = 0;
    logic        l_wr   = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic [3:0]  l_strb = '0;
    int          t_done = 0;

    // next command's completer behaviour, attached at acceptance
    int          nx_w  = 0;
    logic [31:0] nx_rd = '0;

    logic acc_flag  = 1'b0;
    logic done_flag = 1'b0;
    int   acc_gap   = 0;

    // per-transaction observations of DUT pins, snapshotted at completion
    int          o_psel, o_pen, o_rv, o_lat;
    logic        o_seen, o_err, o_pvar, o_pfirst;
    logic [31:0] o_rd, o_pwdata;
    logic [3:0]  o_pstrb;
    int          s_psel, s_pen, s_rv, s_lat;
    logic        s_err, s_pvar;
    logic [31:0] s_rd, s_pwdata;
    logic [3:0]  s_pstrb;

    int   d, alen;
    logic e_cr, e_psel, e_pen, e_rv, e_err;
    logic [31:0] e_rd;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("reset_ctrl", {58'd0, bus.cmd_ready, bus.psel, bus.penable, bus.pwrite,
                               bus.rsp_valid, bus.rsp_err}, 64'd0);
            chk("reset_addr_wdata", {bus.paddr, bus.pwdata}, 64'd0);
            chk("reset_strb_rdata", {28'd0, bus.pstrb, bus.rsp_rdata}, 64'd0);
            m_live = 1'b0; m_has = 1'b0; acc_flag = 1'b0; done_flag = 1'b0;
            l_wr = 1'b0; l_addr = '0; l_wdata = '0; l_strb = '0;
        end else begin
            e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
            if (m_has) begin
                d    = cyc - m_tacc;
                alen = (m_w >= TIMEOUT) ? TIMEOUT : m_w + 1;
                e_psel = (d >= 1) && (d <= 1 + alen);
                e_pen  = (d >= 2) && (d <= 1 + alen);
                e_rv   = (d >= 2 + alen);
            end
            e_cr = m_live && !m_has;
            chk("cmd_ready", {63'd0, bus.cmd_ready}, {63'd0, e_cr});
            chk("psel",      {63'd0, bus.psel},      {63'd0, e_psel});
            chk("penable",   {63'd0, bus.penable},   {63'd0, e_pen});
            chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, e_rv});
            chk("pwrite",    {63'd0, bus.pwrite},    {63'd0, l_wr});
            chk("paddr",     {32'd0, bus.paddr},     {32'd0, l_addr});
            chk("pwdata",    {32'd0, bus.pwdata},    {32'd0, l_wdata});
            chk("pstrb",     {60'd0, bus.pstrb},     {60'd0, l_strb});
            if (e_rv) begin
                e_err = (m_w >= TIMEOUT);
                e_rd  = (e_err || m_wr) ? 32'd0 : m_rd;
                chk("rsp_err",   {63'd0, bus.rsp_err},   {63'd0, e_err});
                chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e_rd});
            end

            if (m_has) begin
                if (bus.psel) begin
                    o_psel++;
                    if (!o_pfirst) begin o_pstrb = bus.pstrb; o_pfirst = 1'b1; end
                    else if (bus.pstrb !== o_pstrb) o_pvar = 1'b1;
                end
                if (bus.penable) begin o_pen++; o_pwdata = bus.pwdata; end
                if (bus.rsp_valid) begin
                    o_rv++;
                    if (!o_seen) begin
                        o_seen = 1'b1; o_lat = cyc - m_tacc;
                        o_rd = bus.rsp_rdata; o_err = bus.rsp_err;
                    end
                end
            end

            if (e_rv && bus.rsp_ready) begin
                m_has = 1'b0; t_done = cyc; done_flag = 1'b1;
                s_psel = o_psel; s_pen = o_pen; s_rv = o_rv; s_lat = o_lat;
                s_err = o_err; s_rd = o_rd; s_pwdata = o_pwdata;
                s_pstrb = o_pstrb; s_pvar = o_pvar;
            end else if (e_cr && bus.cmd_valid) begin
                m_has = 1'b1; m_tacc = cyc; acc_gap = cyc - t_done;
                m_wr = bus.cmd_write; m_addr = bus.cmd_addr; m_wdata = bus.cmd_wdata;
                m_strb = bus.cmd_strb; m_w = nx_w; m_rd = nx_rd;
                l_wr = m_wr; l_addr = m_addr; l_wdata = m_wdata;
                l_strb = m_wr ? m_strb : 4'h0;
                o_psel = 0; o_pen = 0; o_rv = 0; o_lat = 0; o_seen = 1'b0;
                o_pfirst = 1'b0; o_pvar = 1'b0; o_err = 1'b0; o_rd = '0; o_pwdata = '0;
                acc_flag = 1'b1;
            end
            m_live = 1'b1;
        end
    end

    // APB completer: answers on the ACCESS cycle indexed by the wait count.
    initial begin
        int k;
        k = 0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.psel && bus.penable) begin
                if (k == m_w) begin bus.pready = 1'b1; bus.prdata = m_rd; end
                else begin bus.pready = 1'b0; bus.prdata = $urandom; end
                k++;
            end else begin
                k = 0;
                bus.pready = 1'($urandom_range(0, 1));
                bus.prdata = $urandom;
            end
        end
    end

    // Response consumer: holds rsp_ready low for rr_delay RESP cycles.
    int rr_delay = 0;
    initial begin
        int rc;
        rc = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.rsp_valid) begin
                bus.rsp_ready = (rc >= rr_delay);
                rc++;
            end else begin
                rc = 0;
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input int wt, input logic [31:0] rd);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a;
        bus.cmd_wdata = wd; bus.cmd_strb = s;
        nx_w = wt; nx_rd = rd;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (acc_flag) begin
                acc_flag = 1'b0; done_flag = 1'b0; ok = 1'b1;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done_flag) begin done_flag = 1'b0; ok = 1'b1; break; end
        end
        if (!ok) chk("response_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_strb  = '0;

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {63'd0, bus.cmd_ready}, 64'd1);

        // Write, completer ready at once
        issue(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 0, 32'h0);
        wait_done();
        chk("wr_psel_cycles", 64'(s_psel), 64'd2);
        chk("wr_pen_cycles",  64'(s_pen),  64'd1);
        chk("wr_rsp_latency", 64'(s_lat),  64'd3);
        chk("wr_pwdata",      {32'd0, s_pwdata}, 64'hA5A5_1234);
        chk("wr_err",         {63'd0, s_err}, 64'd0);

        // Read with three wait cycles
        issue(1'b0, 32'h10, 32'h0BAD_0BAD, 4'hF, 3, 32'hDEAD_BEEF);
        wait_done();
        chk("rd_pen_cycles", 64'(s_pen), 64'd4);
        chk("rd_pstrb",      {60'd0, s_pstrb}, 64'd0);
        chk("rd_rdata",      {32'd0, s_rd}, 64'hDEAD_BEEF);
        chk("rd_err",        {63'd0, s_err}, 64'd0);

        // Read, completer never ready
        issue(1'b0, 32'h20, 32'h0, 4'hF, 20, 32'h1234_5678);
        wait_done();
        chk("to_pen_cycles",  64'(s_pen),  64'd16);
        chk("to_psel_cycles", 64'(s_psel), 64'd17);
        chk("to_rsp_latency", 64'(s_lat),  64'd18);
        chk("to_err",         {63'd0, s_err}, 64'd1);
        chk("to_rdata",       {32'd0, s_rd}, 64'd0);

        // Strobe 0x5 write, slow consumer, concurrent read held off
        rr_delay = 5;
        issue(1'b1, 32'h30, 32'h5555_AAAA, 4'h5, 1, 32'h0);
        issue(1'b0, 32'h34, 32'h0, 4'hF, 0, 32'hCAFE_F00D);
        chk("hold_pstrb",      {60'd0, s_pstrb}, 64'h5);
        chk("hold_pstrb_var",  {63'd0, s_pvar}, 64'd0);
        chk("hold_rsp_cycles", 64'(s_rv), 64'd6);
        chk("hold_accept_gap", 64'(acc_gap), 64'd1);
        rr_delay = 0;
        wait_done();
        chk("hold_rd_rdata", {32'd0, s_rd}, 64'hCAFE_F00D);

        // Reset in the middle of ACCESS
        issue(1'b0, 32'h40, 32'h0, 4'hF, 6, 32'h1111_2222);
        @(posedge clk); #1;
        chk("mid_access_penable", {63'd0, bus.penable}, 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_drop_psel",    {63'd0, bus.psel},      64'd0);
        chk("rst_drop_penable", {63'd0, bus.penable},   64'd0);
        chk("rst_drop_rsp",     {63'd0, bus.rsp_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 32'h44, 32'h7777_8888, 4'h3, 0, 32'h0);
        wait_done();
        chk("post_rst_latency", 64'(s_lat), 64'd3);
        chk("post_rst_err",     {63'd0, s_err}, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int r, wt;
            r = $urandom_range(0, 9);
            if (r == 0)      wt = 16 + $urandom_range(0, 4);
            else if (r == 1) wt = 15;
            else             wt = $urandom_range(0, 4);
            rr_delay = $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), $urandom, $urandom,
                  4'($urandom_range(0, 15)), wt, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        wait_done();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width; STRB_W = DATA_W/8.
REQ-003 Parameter TIMEOUT, default 16, maximum number of ACCESS cycles with pready low before the transfer is aborted; legal range 1..255.
REQ-004 pclk  in  1  single clock; all state changes on its rising edge.
REQ-005 presetn  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  command request from the local requester.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-008 cmd_write / cmd_addr / cmd_wdata / cmd_strb  in  1 / ADDR_W / DATA_W / STRB_W  command fields.
REQ-009 rsp_valid  out  1  response available; rsp_ready  in  1  response consumed when both are high.
REQ-010 rsp_rdata  out  DATA_W  read data; rsp_err  out  1  timeout abort flag.
REQ-011 psel, penable, pwrite  out  1 each; paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  STRB_W: APB requester outputs.
REQ-012 prdata  in  DATA_W, pready  in  1: APB completer returns.

Function
REQ-013 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-014 cmd_ready SHALL be high only in IDLE.
REQ-015 A command accepted in IDLE SHALL be registered, and the FSM SHALL enter SETUP on the next edge.
REQ-016 SETUP SHALL last exactly 1 cycle with psel=1 and penable=0; paddr, pwrite, pwdata and pstrb SHALL be driven from the registered command.
REQ-017 In ACCESS, psel=1 and penable=1; all other APB outputs SHALL stay stable until the phase ends.
REQ-018 In ACCESS with pready=1 at an edge, the FSM SHALL capture prdata into rsp_rdata for reads (writes: rsp_rdata=0), set rsp_err=0, and enter RESP.
REQ-019 In ACCESS with pready=0, the wait counter SHALL increment each cycle.
REQ-020 When the wait counter equals TIMEOUT with pready still 0, the block SHALL abort: rsp_err=1, rsp_rdata=0, enter RESP.
REQ-021 The wait counter SHALL clear on entry to SETUP.
REQ-022 In RESP: psel=0, penable=0, rsp_valid=1; rsp_rdata and rsp_err SHALL be held until rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-023 Minimum command-to-command period SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP); the back-to-back minimum applies with pready=1 and rsp_ready=1.
REQ-024 For reads, pstrb SHALL be driven 0 regardless of cmd_strb.
REQ-025 For writes, pstrb SHALL equal cmd_strb; an all-zero strobe SHALL be issued unchanged.
REQ-026 Outside SETUP and ACCESS, paddr, pwdata and pstrb SHALL hold their last value; psel and penable SHALL be 0.
REQ-027 penable SHALL never be 1 while psel is 0.

Reset
REQ-028 While presetn=0: FSM=IDLE, wait counter=0, and all outputs 0 except cmd_ready=0.
REQ-029 cmd_ready SHALL rise on the first edge after presetn deasserts.
REQ-030 Reset asserted during SETUP, ACCESS or RESP SHALL drop psel, penable and rsp_valid immediately, with no response generated.

Structure
REQ-031 Package apb_pkg SHALL hold the FSM state enum and a packed apb_cmd_t struct {write, addr, wdata, strb}.
REQ-032 Sub-module apb_wdog SHALL implement the wait counter, with inputs clr and inc and output expired.

Verification
REQ-033 Write to 0x10 with wdata 0xA5A5_1234, strb 0xF, pready tied 1 -> psel high for 2 cycles, penable high for 1 cycle, pwdata=0xA5A5_1234, rsp_valid 3 cycles after acceptance, rsp_err=0.
REQ-034 Read from 0x10, completer returns 0xDEAD_BEEF after 3 wait cycles -> ACCESS lasts 4 cycles, pstrb=0, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-035 Read with pready stuck 0 and TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel low the following cycle.
REQ-036 Hold rsp_ready=0 for 5 cycles with cmd_valid high -> cmd_ready stays 0 and rsp fields stay stable; second command accepted the cycle after rsp_ready=1.
REQ-037 Assert presetn=0 mid-ACCESS -> psel and penable drop within the same cycle, no rsp_valid; the next command after reset completes normally.
REQ-038 Write with strb 0x5 -> pstrb=0x5 throughout SETUP and ACCESS; a concurrent read command is held off by cmd_ready=0 until the write's response is consumed.
